sram_like_arbiter: RTL

Two-to-one arbiter that merges the CPU's instruction-fetch and data-access sram-like channels onto a single downstream sram-like memory port. It sits between the core's IF/MEM memory interfaces and the shared memory or bus bridge. It tracks up to `OT_DEPTH` accepted-but-unanswered requests in an in-order owner FIFO, so each `mem_data_ok` is routed back to the channel that issued the request.

---
 rtl/sram_like_arbiter_pkg.sv | 7 +
 rtl/sram_like_arbiter_if.sv | 14 +
 rtl/sram_like_arbiter_owner_fifo.sv | 40 ++++
 rtl/sram_like_arbiter.sv | 55 +++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// mem_if_pkg: source ids and transfer-size encodings shared by the memory-interface blocks
package mem_if_pkg;
  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram-like channel, request fields plus accept/response strobes
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master(output req, wr, size, addr, wstrb, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, addr, wstrb, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter_owner_fifo.sv
// owner_fifo: in-order record of which channel owns each outstanding memory request
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  logic [DEPTH-1:0] slots;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == CAP;
  assign empty = count == '0;
  assign head = slots[rp];
  // ring buffer of owners; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      slots <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        slots[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges instruction and data sram-like channels onto one memory port
module sram_like_arbiter
  import mem_if_pkg::*;
#(
  parameter int OT_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  sram_like_arbiter_if.slave        inst,
  sram_like_arbiter_if.slave        data,
  sram_like_arbiter_if.master       mem,
  output logic                      resp_err
);
  src_e sel, lock_src;
  logic lock_vld, lock_req, full, empty, head, acc, pop;
  assign sel = lock_vld ? lock_src : (data.req ? SRC_DATA : SRC_INST);
  assign lock_req = lock_src == SRC_DATA ? data.req : inst.req;
  assign mem.req = (inst.req | data.req) & ~full;
  assign mem.wr = sel == SRC_DATA ? data.wr : inst.wr;
  assign mem.size = sel == SRC_DATA ? data.size : inst.size;
  assign mem.addr = sel == SRC_DATA ? data.addr : inst.addr;
  assign mem.wstrb = sel == SRC_DATA ? data.wstrb : inst.wstrb;
  assign mem.wdata = sel == SRC_DATA ? data.wdata : inst.wdata;
  assign acc = mem.req & mem.addr_ok;
  assign inst.addr_ok = acc & (sel == SRC_INST);
  assign data.addr_ok = acc & (sel == SRC_DATA);
  assign pop = mem.data_ok & ~empty;
  assign inst.data_ok = pop & (head == SRC_INST);
  assign data.data_ok = pop & (head == SRC_DATA);
  assign inst.rdata = mem.rdata;
  assign data.rdata = mem.rdata;
  owner_fifo #(.DEPTH(OT_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(acc),
    .pop(pop),
    .din(sel),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // hold the presented source while memory stalls; release on accept or when its master withdraws
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_INST;
    end else begin
      lock_vld <= mem.req & ~mem.addr_ok & ~(lock_vld & ~lock_req);
      lock_src <= sel;
    end
  // sticky flag for a response that has no outstanding owner
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) resp_err <= 1'b0;
    else if (mem.data_ok & empty) resp_err <= 1'b1;
endmodule
